// File: rtl/muldiv_seq_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      FUNC_MUL, FUNC_MULH, FUNC_MULHSU, FUNC_DIV, FUNC_REM: s = 1'b1;
      default:                                             s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      FUNC_MUL, FUNC_MULH, FUNC_DIV, FUNC_REM: s = 1'b1;
      default:                                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add for multiply, restoring
// shift-subtract for divide. hi/lo form the double-width working register.
module muldiv_step
  #(parameter int XLEN = 32)
  (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
  );

  logic [XLEN:0]   w_addend;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;

  // Single add-shift or subtract-shift step
  always_comb begin
    w_addend = i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}};
    w_sum    = {1'b0, i_hi} + w_addend;
    w_shift  = {i_hi, i_lo[XLEN-1]};
    // Remainder stays below the divisor, so a non-borrowing difference fits XLEN bits
    w_borrow = (w_shift < {1'b0, i_b});
    w_diff   = w_shift[XLEN-1:0] - i_b;
    if (i_is_div) begin
      if (w_borrow) begin
        o_hi = w_shift[XLEN-1:0];
      end else begin
        o_hi = w_diff;
      end
      o_lo = {i_lo[XLEN-2:0], ~w_borrow};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 1 bit per cycle on operand magnitudes,
// sign correction in FIX, one-cycle o_finish pulse with o_result.
module muldiv_seq
  import muldiv_seq_pkg::*;
  #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
  )
  (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_finish,
    output logic [XLEN-1:0] o_result
  );

  localparam logic [XLEN-1:0]   LP_ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   LP_ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   LP_ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   LP_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] LP_ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LP_CNT_0   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  LP_CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LP_CNT_END = CNT_W'(XLEN-1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_finish;

  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_func3[2]),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Operand magnitudes, sign flags and early-out detection at accept
  always_comb begin
    w_neg_a       = rs1_is_signed(i_func3) & i_rs1_data[XLEN-1];
    w_neg_b       = rs2_is_signed(i_func3) & i_rs2_data[XLEN-1];
    w_abs_a       = w_neg_a ? (~i_rs1_data + LP_ONE) : i_rs1_data;
    w_abs_b       = w_neg_b ? (~i_rs2_data + LP_ONE) : i_rs2_data;
    w_special     = 1'b0;
    w_special_res = LP_ZERO;
    if (i_func3[2]) begin
      if (i_rs2_data == LP_ZERO) begin
        w_special     = 1'b1;
        w_special_res = i_func3[1] ? i_rs1_data : LP_ONES;
      end else if (!i_func3[0] && (i_rs1_data == LP_MIN_NEG) && (i_rs2_data == LP_ONES)) begin
        w_special     = 1'b1;
        w_special_res = i_func3[1] ? LP_ZERO : LP_MIN_NEG;
      end else begin
        w_special     = 1'b0;
      end
    end else begin
      w_special = 1'b0;
    end
  end

  // Sign correction and result word selection during FIX
  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg_a ^ r_neg_b) begin
      w_prod = ~w_prod + LP_ONE_2X;
      w_quo  = ~r_lo + LP_ONE;
    end else begin
      w_quo  = r_lo;
    end
    // Remainder follows the dividend's sign
    w_rem = r_neg_a ? (~r_hi + LP_ONE) : r_hi;
    case (r_func3)
      FUNC_MUL:                          w_fix_res = w_prod[XLEN-1:0];
      FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      FUNC_DIV, FUNC_DIVU:               w_fix_res = w_quo;
      FUNC_REM, FUNC_REMU:               w_fix_res = w_rem;
      default:                           w_fix_res = LP_ZERO;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, accept decode and busy
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = i_start & ~i_kill & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    o_busy      = w_accept | (r_state == ST_CALC) | (r_state == ST_FIX);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? ST_DONE : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (i_kill) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_CNT_END) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIX: begin
        if (i_kill) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= LP_CNT_0;
      r_func3 <= 3'b000;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_hi    <= LP_ZERO;
      r_lo    <= LP_ZERO;
      r_b     <= LP_ZERO;
    end else if (w_accept) begin
      r_cnt   <= LP_CNT_0;
      r_func3 <= i_func3;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_hi    <= LP_ZERO;
      r_lo    <= w_abs_a;
      r_b     <= w_abs_b;
    end else if ((r_state == ST_CALC) && !i_kill) begin
      r_cnt   <= r_cnt + LP_CNT_1;
      r_hi    <= w_step_hi;
      r_lo    <= w_step_lo;
    end else begin
      r_cnt   <= LP_CNT_0;
    end
  end

  // Registered result and finish pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= LP_ZERO;
      r_finish <= 1'b0;
    end else begin
      r_finish <= (w_state_nxt == ST_DONE);
      if (w_accept && w_special) begin
        r_result <= w_special_res;
      end else if ((r_state == ST_FIX) && !i_kill) begin
        r_result <= w_fix_res;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign o_finish = r_finish;
  assign o_result = r_result;

endmodule
